// File: rtl/my_arb_pkg.sv
// ============================================================================
// Module  : my_arb_pkg
// Purpose : Shared types, sizes and the round-robin pick function for the
//           8-way arbiter/sequencer in front of my_mux_16_8_way.
// Contents: arb_state_t (IDLE, BUSY), N_REQ, SEL_W, DATA_W, rr_pick().
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package my_arb_pkg;

    localparam int N_REQ  = 8;
    localparam int SEL_W  = 3;
    localparam int DATA_W = 16;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    // Return the first set request bit, scanning ptr, ptr+1, ... ptr+7
    // (mod 8). The 3-bit index addition wraps for free. Returns 0 when no
    // bit is set; callers only use the result when req != 0.
    function automatic logic [SEL_W-1:0] rr_pick(
        input logic [N_REQ-1:0] req,
        input logic [SEL_W-1:0] ptr
    );
        logic [SEL_W-1:0] w_idx;
        logic             w_found;
        logic [SEL_W-1:0] w_pick;
        w_pick  = '0;
        w_found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            w_idx = ptr + SEL_W'(k);
            if (!w_found && req[w_idx]) begin
                w_pick  = w_idx;
                w_found = 1'b1;
            end
        end
        return w_pick;
    endfunction

endpackage

`default_nettype wire

// File: rtl/my_mux_16_8_way.sv
// ============================================================================
// Module  : my_mux_16_8_way
// Purpose : 16-bit, 8-input combinational multiplexer.
// Ports   : a..h  in  16  data inputs (sel 0..7)
//           sel   in  3   select
//           out   out 16  selected word
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module my_mux_16_8_way (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [15:0] c,
    input  logic [15:0] d,
    input  logic [15:0] e,
    input  logic [15:0] f,
    input  logic [15:0] g,
    input  logic [15:0] h,
    input  logic [2:0]  sel,
    output logic [15:0] out
);

    always_comb begin
        out = a;
        case (sel)
            3'd0:    out = a;
            3'd1:    out = b;
            3'd2:    out = c;
            3'd3:    out = d;
            3'd4:    out = e;
            3'd5:    out = f;
            3'd6:    out = g;
            default: out = h;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/my_arbiter_16_8_way.sv
// ============================================================================
// Module  : my_arbiter_16_8_way
// Purpose : Round-robin arbiter/sequencer sharing one my_mux_16_8_way among
//           eight word sources, presenting the granted word on a
//           valid/ready handshake and pulsing gnt to the winner on accept.
// Ports   : clk        in  1   clock (rising edge)
//           reset      in  1   synchronous active-high reset
//           req        in  8   per-source request (bit i -> data_<i>)
//           data_a..h  in  16  source words
//           gnt        out 8   one-hot accept pulse for the current winner
//           sel        out 3   registered mux select (current/last winner)
//           out        out 16  selected word
//           out_valid  out 1   out holds a granted beat
//           out_ready  in  1   consumer accepts the beat
// Config  : MY_ARB_BURST_EN - when defined, a winner still requesting keeps
//           the grant for up to MAX_BURST back-to-back beats.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module my_arbiter_16_8_way
    import my_arb_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  req,
    input  logic [15:0] data_a,
    input  logic [15:0] data_b,
    input  logic [15:0] data_c,
    input  logic [15:0] data_d,
    input  logic [15:0] data_e,
    input  logic [15:0] data_f,
    input  logic [15:0] data_g,
    input  logic [15:0] data_h,
    output logic [7:0]  gnt,
    output logic [2:0]  sel,
    output logic [15:0] out,
    output logic        out_valid,
    input  logic        out_ready
);

    arb_state_t       state_q;
    logic [SEL_W-1:0] sel_q;
    logic [SEL_W-1:0] ptr_q;
    logic             out_valid_q;
    logic             w_fire;

`ifdef MY_ARB_BURST_EN
    logic [3:0]       cnt_q;
    logic             w_burst_more;

    // Stay on the same source while it keeps requesting and the burst
    // budget is not yet exhausted.
    assign w_burst_more = req[sel_q] &&
                          (({1'b0, cnt_q} + 5'd1) < 5'(MAX_BURST));
`else
    logic             w_unused_cfg;
    assign w_unused_cfg = (MAX_BURST > 0);
`endif

    assign w_fire = out_valid_q && out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            ptr_q       <= '0;
            out_valid_q <= 1'b0;
`ifdef MY_ARB_BURST_EN
            cnt_q       <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (|req) begin
                        sel_q       <= rr_pick(req, ptr_q);
                        state_q     <= BUSY;
                        out_valid_q <= 1'b1;
`ifdef MY_ARB_BURST_EN
                        cnt_q       <= '0;
`endif
                    end
                end
                BUSY: begin
                    // req is deliberately not looked at here except for
                    // burst continuation: an early drop never cancels a beat.
                    if (w_fire) begin
`ifdef MY_ARB_BURST_EN
                        if (w_burst_more) begin
                            cnt_q <= cnt_q + 4'd1;
                        end else begin
                            ptr_q       <= sel_q + 3'd1;
                            state_q     <= IDLE;
                            out_valid_q <= 1'b0;
                        end
`else
                        ptr_q       <= sel_q + 3'd1;
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
`endif
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        gnt = '0;
        if (w_fire) begin
            gnt[sel_q] = 1'b1;
        end
    end

    assign sel       = sel_q;
    assign out_valid = out_valid_q;

    my_mux_16_8_way u_mux (
        .a   (data_a),
        .b   (data_b),
        .c   (data_c),
        .d   (data_d),
        .e   (data_e),
        .f   (data_f),
        .g   (data_g),
        .h   (data_h),
        .sel (sel_q),
        .out (out)
    );

endmodule

`default_nettype wire
